comp_bin_seq: RTL and testbench

- Sequential, parametrised successor to the combinational magnitude comparator.
- Compares two N-bit operands W bits per cycle, starting at the MSB chunk.
- Supports unsigned and two's-complement modes; in signed mode the operand MSB is inverted to map to offset binary.
- Start/busy/done handshake. Used where wide operands would make a flat comparator miss timing.

---
 rtl/comp_bin_pkg.sv | 30 +++
 rtl/comp_bin_chunk.sv | 27 ++
 rtl/comp_bin_seq.sv | 140 ++++++++++++++
 tb/tb_comp_bin_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_bin_pkg.sv
// Shared types for the sequential chunked magnitude comparator: FSM states,
// comparison result encoding and its decode onto the three result flags.
package comp_bin_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      RES_NONE = 2'd0,
      RES_GT   = 2'd1,
      RES_EQ   = 2'd2,
      RES_LT   = 2'd3
   } res_t;

   // Returns {mayor, igual, menor}
   function automatic logic [2:0] res_flags(input res_t res);
      logic [2:0] flags;
      case (res)
         RES_GT:  flags = 3'b100;
         RES_EQ:  flags = 3'b010;
         RES_LT:  flags = 3'b001;
         default: flags = 3'b000;
      endcase
      return flags;
   endfunction

endpackage

// File: rtl/comp_bin_chunk.sv
// Combinational W-bit chunk compare; i_Flip_Msb inverts the top bit of both
// operands so a two's-complement MSB chunk orders as offset binary.
module comp_bin_chunk #(
   parameter int W = 8
) (
   input  logic [W-1:0] i_A,
   input  logic [W-1:0] i_B,
   input  logic         i_Flip_Msb,
   output logic         o_Gt,
   output logic         o_Eq
);

   logic [W-1:0] w_a;
   logic [W-1:0] w_b;

   // Offset-binary mapping of the chunk operands
   always_comb begin
      w_a        = i_A;
      w_b        = i_B;
      w_a[W-1]   = i_A[W-1] ^ i_Flip_Msb;
      w_b[W-1]   = i_B[W-1] ^ i_Flip_Msb;
   end

   assign o_Gt = (w_a > w_b);
   assign o_Eq = (w_a == w_b);

endmodule

// File: rtl/comp_bin_seq.sv
// Sequential N-bit magnitude comparator walking W-bit chunks from the MSB.
// Optional macro COMP_BIN_SEQ_FIXED_LAT_EN: always walk all chunks (fixed latency).
module comp_bin_seq #(
   parameter int N = 32,
   parameter int W = 8
) (
   input  logic         i_Clk,
   input  logic         i_Rst,
   input  logic         i_Start,
   input  logic         i_Signed,
   input  logic [N-1:0] i_A,
   input  logic [N-1:0] i_B,
   output logic         o_Busy,
   output logic         o_Done,
   output logic         o_Mayor,
   output logic         o_Igual,
   output logic         o_Menor
);
   import comp_bin_pkg::*;

   localparam int NCHUNK = N / W;
   localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   generate
      if ((W < 1) || (W > N) || ((N % W) != 0)) begin : g_bad_params
         $error("comp_bin_seq: N must be a positive multiple of W with 1 <= W <= N");
      end
   endgenerate

   state_t         r_state;
   res_t           r_res;
   logic [IW-1:0]  r_idx;
   logic [N-1:0]   r_a;
   logic [N-1:0]   r_b;
   logic           r_signed;
`ifdef COMP_BIN_SEQ_FIXED_LAT_EN
   logic           r_decided;
`endif

   logic [NCHUNK-1:0][W-1:0] w_a_vec;
   logic [NCHUNK-1:0][W-1:0] w_b_vec;
   logic                     w_flip;
   logic                     w_gt;
   logic                     w_eq;
   res_t                     w_res;

   assign w_a_vec = r_a;
   assign w_b_vec = r_b;
   assign w_flip  = r_signed && (r_idx == IW'(NCHUNK - 1));

   comp_bin_chunk #(.W(W)) u_chunk (
      .i_A        (w_a_vec[r_idx]),
      .i_B        (w_b_vec[r_idx]),
      .i_Flip_Msb (w_flip),
      .o_Gt       (w_gt),
      .o_Eq       (w_eq)
   );

   // Encode the current chunk outcome
   always_comb begin
      w_res = RES_NONE;
      if (w_eq) begin
         w_res = RES_EQ;
      end else if (w_gt) begin
         w_res = RES_GT;
      end else begin
         w_res = RES_LT;
      end
   end

   // Control FSM; outputs are registered decodes of the current state
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         r_state  <= IDLE;
         r_res    <= RES_NONE;
         r_idx    <= {IW{1'b0}};
         r_a      <= {N{1'b0}};
         r_b      <= {N{1'b0}};
         r_signed <= 1'b0;
`ifdef COMP_BIN_SEQ_FIXED_LAT_EN
         r_decided <= 1'b0;
`endif
         o_Busy   <= 1'b0;
         o_Done   <= 1'b0;
         o_Mayor  <= 1'b0;
         o_Igual  <= 1'b0;
         o_Menor  <= 1'b0;
      end else begin
         o_Busy <= (r_state != IDLE);
         o_Done <= (r_state == DONE);
         if (r_state == DONE) begin
            {o_Mayor, o_Igual, o_Menor} <= res_flags(r_res);
         end
         case (r_state)
            IDLE: begin
               if (i_Start) begin
                  r_a      <= i_A;
                  r_b      <= i_B;
                  r_signed <= i_Signed;
                  r_idx    <= IW'(NCHUNK - 1);
`ifdef COMP_BIN_SEQ_FIXED_LAT_EN
                  r_decided <= 1'b0;
`endif
                  r_state  <= CMP;
               end
            end
            CMP: begin
`ifdef COMP_BIN_SEQ_FIXED_LAT_EN
               // First unequal chunk from the MSB is sticky
               if (!r_decided) begin
                  r_res <= w_res;
                  if (!w_eq) begin
                     r_decided <= 1'b1;
                  end
               end
               if (r_idx == {IW{1'b0}}) begin
                  r_state <= DONE;
               end else begin
                  r_idx <= r_idx - IW'(1);
               end
`else
               if (!w_eq || (r_idx == {IW{1'b0}})) begin
                  r_res   <= w_res;
                  r_state <= DONE;
               end else begin
                  r_idx <= r_idx - IW'(1);
               end
`endif
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_comp_bin_seq.sv
// Self-checking bench for comp_bin_seq (N=32, W=8): vector table, random
// vectors against a behavioural model, and hand-written corner sequences.
module tb_comp_bin_seq;

   localparam int N      = 32;
   localparam int W      = 8;
   localparam int NCHUNK = N / W;

   localparam logic [2:0] F_GT = 3'b100;
   localparam logic [2:0] F_EQ = 3'b010;
   localparam logic [2:0] F_LT = 3'b001;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sgn;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic         mayor;
   logic         igual;
   logic         menor;

   always #5 clk = ~clk;

   comp_bin_seq #(.N(N), .W(W)) dut (
      .i_Clk    (clk),
      .i_Rst    (rst),
      .i_Start  (start),
      .i_Signed (sgn),
      .i_A      (a),
      .i_B      (b),
      .o_Busy   (busy),
      .o_Done   (done),
      .o_Mayor  (mayor),
      .o_Igual  (igual),
      .o_Menor  (menor)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0] flags;
      int         due;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic         s;
      logic [N-1:0] va;
      logic [N-1:0] vb;
      logic [2:0]   flags;
      int           k;
   } vec_t;
   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int lat(input int k);
`ifdef COMP_BIN_SEQ_FIXED_LAT_EN
      return 1 + NCHUNK;
`else
      return 1 + k;
`endif
   endfunction

   // Deciding chunk number counted from the MSB chunk (1..NCHUNK)
   function automatic int model_k(input logic [N-1:0] xa, input logic [N-1:0] xb);
      logic [N-1:0] x;
      x = xa ^ xb;
      for (int p = N - 1; p >= 0; p--) begin
         if (x[p]) return NCHUNK - (p / W);
      end
      return NCHUNK;
   endfunction

   function automatic logic [2:0] model_flags(input logic s, input logic [N-1:0] xa, input logic [N-1:0] xb);
      if (xa == xb) return F_EQ;
      if (s) return ($signed(xa) > $signed(xb)) ? F_GT : F_LT;
      return (xa > xb) ? F_GT : F_LT;
   endfunction

   // Scoreboard monitor: every o_Done pulse must match the oldest expectation
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            check("done_without_request", 32'(done), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("flags", 32'({mayor, igual, menor}), 32'(e.flags));
            check("done_cycle", 32'(cyc), 32'(e.due));
         end
      end
   end

   task automatic wait_done(input bit from_start);
      bit got;
      got = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         #1;
         check("busy", 32'(busy), (from_start && (n == 0)) ? 32'd0 : 32'd1);
         if (sb.size() == 0) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         check("done_timeout", 32'(sb.size()), 32'd0);
         sb.delete();
      end
   endtask

   task automatic run_cmp(input logic s, input logic [N-1:0] va, input logic [N-1:0] vb,
                          input logic [2:0] f, input int k);
      exp_t e;
      sgn   = s;
      a     = va;
      b     = vb;
      start = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      e.flags = f;
      e.due   = cyc + lat(k);
      sb.push_back(e);
      a   = $urandom;
      b   = $urandom;
      sgn = ~s;
      wait_done(1'b1);
   endtask

   initial begin
      exp_t e;
      logic         rs;
      logic [N-1:0] ra;
      logic [N-1:0] rb;

      vecs[0]  = '{1'b0, 32'h12345678, 32'h12345679, F_LT, 4};
      vecs[1]  = '{1'b0, 32'h80000000, 32'h7FFFFFFF, F_GT, 1};
      vecs[2]  = '{1'b1, 32'h80000000, 32'h7FFFFFFF, F_LT, 1};
      vecs[3]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE, F_GT, 4};
      vecs[4]  = '{1'b0, 32'hDEADBEEF, 32'hDEADBEEF, F_EQ, 4};
      vecs[5]  = '{1'b1, 32'hDEADBEEF, 32'hDEADBEEF, F_EQ, 4};
      vecs[6]  = '{1'b0, 32'h00FF0000, 32'h00FEFFFF, F_GT, 2};
      vecs[7]  = '{1'b1, 32'h00000000, 32'hFFFFFFFF, F_GT, 1};
      vecs[8]  = '{1'b0, 32'h00000000, 32'hFFFFFFFF, F_LT, 1};
      vecs[9]  = '{1'b1, 32'h7FFFFFFF, 32'h80000000, F_GT, 1};
      vecs[10] = '{1'b0, 32'h0000AB00, 32'h0000AC00, F_LT, 3};

      rst   = 1'b1;
      start = 1'b0;
      sgn   = 1'b0;
      a     = '0;
      b     = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_flags", 32'({mayor, igual, menor}), 32'd0);

      for (int i = 0; i < 11; i++) begin
         run_cmp(vecs[i].s, vecs[i].va, vecs[i].vb, vecs[i].flags, vecs[i].k);
      end

      // Equal result must hold through idle cycles
      run_cmp(1'b0, 32'hDEADBEEF, 32'hDEADBEEF, F_EQ, 4);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("eq_hold", 32'({mayor, igual, menor}), 32'(F_EQ));
      end

      for (int i = 0; i < 16; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         case ($urandom_range(0, 2))
            0:       rb = $urandom;
            1:       rb = ra ^ (32'd1 << $urandom_range(0, N - 1));
            default: rb = ra;
         endcase
         run_cmp(rs, ra, rb, model_flags(rs, ra, rb), model_k(ra, rb));
      end

      // Busy collision: repeated starts while busy are ignored
      sgn   = 1'b0;
      a     = 32'd1;
      b     = 32'd2;
      start = 1'b1;
      @(posedge clk);
      #1;
      e.flags = F_LT;
      e.due   = cyc + lat(4);
      sb.push_back(e);
      a = 32'd9;
      repeat (3) @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(1'b0);
      run_cmp(1'b0, 32'd9, 32'd2, F_GT, 4);

      // Reset mid-operation aborts without a done pulse
      sgn   = 1'b0;
      a     = 32'd1;
      b     = 32'd2;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_flags", 32'({mayor, igual, menor}), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      @(posedge clk);
      #1;
      check("abort_busy_next", 32'(busy), 32'd0);
      run_cmp(1'b0, 32'd9, 32'd2, F_GT, 4);

      // Reset and start in the same cycle: reset wins
      rst   = 1'b1;
      start = 1'b1;
      a     = 32'd5;
      b     = 32'd3;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      start = 1'b0;
      check("rst_start_busy", 32'(busy), 32'd0);
      repeat (6) @(posedge clk);
      #1;
      check("rst_start_busy_late", 32'(busy), 32'd0);
      check("rst_start_flags", 32'({mayor, igual, menor}), 32'd0);

      run_cmp(1'b1, 32'hFFFFFF00, 32'h00000010, F_LT, 1);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
